// File: rtl/fifo_read_ctrl_pkg.sv
// fifo_read_ctrl_pkg: shared widths, reset values and Gray-code helper for the FIFO read side
package fifo_read_ctrl_pkg;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ADDR_WIDTH = 6;
  localparam int DEF_AEMPTY_THRESH = 4;
  localparam logic RST_EMPTY = 1'b1;
  localparam logic RST_AEMPTY = 1'b1;
  localparam logic RST_VALID = 1'b0;
  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction
endpackage

// File: rtl/fifo_gray2bin.sv
// fifo_gray2bin: Gray to binary conversion, each bit is the XOR of all Gray bits at or above it
module fifo_gray2bin #(
  parameter int W = 7
) (
  input  logic [W-1:0] gray_i,
  output logic [W-1:0] bin_o
);
  for (genvar i = 0; i < W; i++) begin : g_bit
    assign bin_o[i] = ^gray_i[W-1:i];
  end
endmodule

// File: rtl/fifo_read_ctrl.sv
// fifo_read_ctrl: read-domain pointer, empty/level flags and registered FWFT output stage
module fifo_read_ctrl
  import fifo_read_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int AEMPTY_THRESH = DEF_AEMPTY_THRESH
) (
  input  logic                  rd_clk,
  input  logic                  rd_rst,
  input  logic [ADDR_WIDTH:0]   rq2_wptr,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] mem_data,
  output logic [ADDR_WIDTH:0]   rd_ptr,
  output logic                  rd_empty,
  output logic [ADDR_WIDTH:0]   rd_level,
  output logic                  rd_aempty,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data
);
  localparam int PW = ADDR_WIDTH + 1;
  logic [PW-1:0] rbin_q, rbin_d, rgray_q, rgray_d, level_q, level_d, wbin;
  logic empty_q, empty_d, aempty_q, aempty_d, valid_q, valid_d, pop;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  fifo_gray2bin #(.W(PW)) u_wbin (
    .gray_i(rq2_wptr),
    .bin_o (wbin)
  );
  // pop only when a word is available and the output slot is free or draining; flags judge the post-pop pointer
  always_comb begin
    pop = ~empty_q & (~valid_q | m_ready);
    rbin_d = rbin_q + PW'(pop);
    rgray_d = PW'(bin2gray(32'(rbin_d)));
    empty_d = rgray_d == rq2_wptr;
    level_d = wbin - rbin_d;
    aempty_d = level_d <= PW'(AEMPTY_THRESH);
    valid_d = pop | (valid_q & ~m_ready);
    data_d = pop ? mem_data : data_q;
  end
  // state registers with synchronous reset
  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      rbin_q <= '0;
      rgray_q <= '0;
      level_q <= '0;
      empty_q <= RST_EMPTY;
      aempty_q <= RST_AEMPTY;
      valid_q <= RST_VALID;
      data_q <= '0;
    end else begin
      rbin_q <= rbin_d;
      rgray_q <= rgray_d;
      level_q <= level_d;
      empty_q <= empty_d;
      aempty_q <= aempty_d;
      valid_q <= valid_d;
      data_q <= data_d;
    end
  end
  assign rd_addr = rbin_q[ADDR_WIDTH-1:0];
  assign rd_ptr = rgray_q;
  assign rd_empty = empty_q;
  assign rd_level = level_q;
  assign rd_aempty = aempty_q;
  assign m_valid = valid_q;
  assign m_data = data_q;
endmodule

// File: tb/tb_fifo_read_ctrl.sv
// tb_fifo_read_ctrl: random and directed stimulus against a count-based reference model
module tb_fifo_read_ctrl;
  logic rd_clk = 1'b0;
  logic rd_rst = 1'b1;
  logic [6:0] rq2_wptr = '0;
  logic [5:0] rd_addr;
  logic [7:0] mem_data;
  logic [6:0] rd_ptr;
  logic rd_empty, rd_aempty, m_valid;
  logic [6:0] rd_level;
  logic m_ready = 1'b0;
  logic [7:0] m_data;
  logic [7:0] mem [64];
  int n_tests = 0, n_fail = 0;
  int wcnt = 0, rcnt = 0;
  logic [7:0] exp_q[$], wr_log[$], got_q[$];
  bit e_valid = 0, e_empty = 1;
  logic [7:0] e_data = '0;
  int e_level = 0;

  always #5 rd_clk = ~rd_clk;
  assign mem_data = mem[rd_addr];

  fifo_read_ctrl dut (
    .rd_clk(rd_clk), .rd_rst(rd_rst), .rq2_wptr(rq2_wptr), .rd_addr(rd_addr),
    .mem_data(mem_data), .rd_ptr(rd_ptr), .rd_empty(rd_empty), .rd_level(rd_level),
    .rd_aempty(rd_aempty), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data)
  );

  function automatic logic [6:0] gray(input int n);
    logic [6:0] b;
    b = 7'(n % 128);
    return b ^ (b >> 1);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic cycle(input bit rst, input bit wr, input bit rdy, input logic [7:0] wd);
    bit pop;
    if (rst) begin
      wcnt = 0; rcnt = 0;
      exp_q.delete(); wr_log.delete(); got_q.delete();
    end else if (wr && wcnt - rcnt < 64) begin
      mem[wcnt % 64] = wd;
      exp_q.push_back(wd);
      wr_log.push_back(wd);
      wcnt++;
    end
    rd_rst = rst;
    rq2_wptr = gray(wcnt);
    m_ready = rdy;
    if (!rst && m_valid && rdy) got_q.push_back(m_data);
    @(posedge rd_clk);
    if (rst) begin
      e_valid = 0; e_data = '0; e_empty = 1; e_level = 0;
    end else begin
      pop = !e_empty && (!e_valid || rdy);
      if (pop) begin
        e_data = exp_q.pop_front();
        e_valid = 1;
        rcnt++;
      end else if (rdy) e_valid = 0;
      e_level = wcnt - rcnt;
      e_empty = e_level == 0;
    end
    #1;
    chk("empty", rd_empty, e_empty);
    chk("level", rd_level, e_level);
    chk("aempty", rd_aempty, e_level <= 4);
    chk("valid", m_valid, e_valid);
    chk("data", m_data, e_data);
    chk("ptr", rd_ptr, gray(rcnt));
    chk("addr", rd_addr, rcnt % 64);
    @(negedge rd_clk);
  endtask

  task automatic check_order(input string tag, input int n);
    chk({tag, "_count"}, got_q.size(), n);
    for (int i = 0; i < got_q.size() && i < wr_log.size(); i++)
      chk({tag, "_order"}, got_q[i], wr_log[i]);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = '0;
    repeat (3) cycle(1, 0, 0, 0);
    chk("rst_empty", rd_empty, 1);
    chk("rst_valid", m_valid, 0);
    chk("rst_ptr", rd_ptr, 0);
    chk("rst_level", rd_level, 0);
    chk("rst_aempty", rd_aempty, 1);

    cycle(0, 1, 0, 8'hA5);
    chk("single_empty_drop", rd_empty, 0);
    chk("single_valid_early", m_valid, 0);
    cycle(0, 0, 0, 0);
    chk("single_valid", m_valid, 1);
    chk("single_data", m_data, 8'hA5);
    chk("single_empty_back", rd_empty, 1);
    chk("single_ptr", rd_ptr, 7'd1);
    repeat (3) cycle(0, 0, 0, 0);
    chk("single_hold", m_data, 8'hA5);
    cycle(0, 0, 1, 0);
    chk("single_drain", m_valid, 0);

    cycle(1, 0, 0, 0);
    for (int i = 0; i < 10; i++) cycle(0, 1, 1, 8'(i));
    repeat (6) cycle(0, 0, 1, 0);
    check_order("stream", 10);
    chk("stream_level_end", rd_level, 0);

    cycle(1, 0, 0, 0);
    for (int i = 0; i < 24; i++) cycle(0, 1, (i % 4 == 0) || (i % 4 == 3), 8'($urandom));
    for (int i = 0; i < 40; i++) cycle(0, 0, (i % 4 == 0) || (i % 4 == 3), 0);
    check_order("bp", 24);

    cycle(1, 0, 0, 0);
    for (int i = 0; i < 3000 && got_q.size() < 200; i++)
      cycle(0, $urandom_range(0, 9) < 8, $urandom_range(0, 3) != 0, 8'($urandom));
    chk("wrap_past_127", rcnt >= 128, 1);
    check_order("wrap", got_q.size());
    for (int i = 0; i < 70; i++) cycle(0, 1, 0, 8'($urandom));
    repeat (3) cycle(0, 0, 0, 0);
    chk("full_level", rd_level, 64);
    chk("full_aempty", rd_aempty, 0);
    for (int i = 0; i < 100; i++) cycle(0, 0, 1, 0);
    check_order("wrap_drain", wr_log.size());

    cycle(1, 0, 0, 0);
    for (int i = 0; i < 7; i++) cycle(0, 1, 0, 8'($urandom));
    chk("mid_valid_pre", m_valid, 1);
    cycle(1, 0, 0, 0);
    chk("mid_rst_valid", m_valid, 0);
    chk("mid_rst_data", m_data, 0);
    chk("mid_rst_empty", rd_empty, 1);
    chk("mid_rst_level", rd_level, 0);
    chk("mid_rst_ptr", rd_ptr, 0);
    chk("mid_rst_addr", rd_addr, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
